// File: rtl/node_pkg.sv
// rtl/node_pkg.sv - shared types and helpers for the dynamic node keeper and cell benches
package node_pkg;

    // Four-state drain levels are carried as an explicit 2-bit code so z and x survive two-state tools.
    typedef enum logic [1:0] {
        L0 = 2'd0,
        L1 = 2'd1,
        LZ = 2'd2,
        LX = 2'd3
    } lvl_t;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_DRIVEN  = 3'd1,
        ST_FLOAT   = 3'd2,
        ST_DECAYED = 3'd3,
        ST_CONTEND = 3'd4
    } node_state_t;

    function automatic logic is_z(input lvl_t v);
        return v == LZ;
    endfunction

    function automatic logic is_known(input lvl_t v);
        return (v == L0) || (v == L1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and enable
module sat_counter #(
    parameter int              W   = 8,
    parameter logic [W-1:0]    MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            if (clr) begin
                r_q <= '0;
            end else if (inc && (r_q != MAX)) begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dyn_node_keeper.sv
// rtl/dyn_node_keeper.sv - resolves pull-up/pull-down drains onto one dynamic node with charge retention
module dyn_node_keeper
    import node_pkg::*;
#(
    parameter int RETAIN_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sample_en,
    input  lvl_t                                 pu_d,
    input  lvl_t                                 pd_d,
    input  logic                                 clr_sticky,
    output lvl_t                                 node,
    output logic                                 node_known,
    output node_state_t                          node_state,
    output logic [$clog2(RETAIN_CYCLES+1)-1:0]   float_cnt,
    output logic                                 contention_seen,
    output logic [CNT_W-1:0]                     contention_cnt
);

    localparam int FW = $clog2(RETAIN_CYCLES + 1);

    lvl_t        r_node;
    node_state_t r_state;
    logic        r_seen;

    logic w_pu_z;
    logic w_pd_z;
    logic w_contend;
    logic w_driven;
    logic w_float;
    logic w_decay;
    lvl_t w_drv_val;

    assign w_pu_z    = is_z(pu_d);
    assign w_pd_z    = is_z(pd_d);
    assign w_contend = !w_pu_z && !w_pd_z;
    assign w_driven  = w_pu_z ^ w_pd_z;
    assign w_float   = w_pu_z && w_pd_z;
    assign w_drv_val = w_pu_z ? pd_d : pu_d;
    // This float sample is the one that reaches the retention limit (or it was already reached).
    assign w_decay   = (float_cnt >= FW'(RETAIN_CYCLES - 1));

    sat_counter #(
        .W   (FW),
        .MAX (FW'(RETAIN_CYCLES))
    ) u_float_cnt (
        .clk (clk),
        .rst (rst),
        .en  (sample_en),
        .inc (w_float),
        .clr (!w_float),
        .q   (float_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_contention_cnt (
        .clk (clk),
        .rst (rst),
        .en  (sample_en),
        .inc (w_contend),
        .clr (1'b0),
        .q   (contention_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_node  <= LX;
            r_state <= ST_RESET;
            r_seen  <= 1'b0;
        end else begin
            if (sample_en && w_contend) begin
                r_seen <= 1'b1;
            end else if (clr_sticky) begin
                r_seen <= 1'b0;
            end
            if (sample_en) begin
                if (w_contend) begin
                    r_node  <= LX;
                    r_state <= ST_CONTEND;
                end else if (w_driven) begin
                    r_node  <= w_drv_val;
                    r_state <= ST_DRIVEN;
                end else if (w_decay) begin
                    r_node  <= LX;
                    r_state <= ST_DECAYED;
                end else begin
                    // Held charge: from reset or contention the held value is already x.
                    r_state <= ST_FLOAT;
                end
            end
        end
    end

    assign node            = r_node;
    assign node_known      = is_known(r_node);
    assign node_state      = r_state;
    assign contention_seen = r_seen;

endmodule
